// File: rtl/fp_arbiter_rr.sv
// Priority queue selector with round-robin tie-break, optional starvation aging,
// and a grant that stays stable until the downstream dispatcher accepts it.
module fp_arbiter_rr #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int PRIORITY_SIZE    = 4,
  parameter int AGING_ENABLE     = 1,
  parameter int AGE_THRESHOLD    = 8
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NUMBER_OF_QUEUES*PRIORITY_SIZE-1:0]  priorities,
  input  logic [NUMBER_OF_QUEUES-1:0]                free,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]        selection,
  output logic                                       selection_valid,
  input  logic                                       selection_ready,
  output logic [PRIORITY_SIZE-1:0]                   selection_priority
);

  localparam int N     = NUMBER_OF_QUEUES;
  localparam int P     = PRIORITY_SIZE;
  localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

  localparam logic [7:0]       AGE_MAX = 8'(AGE_THRESHOLD);
  localparam logic [SEL_W-1:0] LAST_ID = SEL_W'(NUMBER_OF_QUEUES - 1);

  logic [N-1:0]     eligible;
  logic [P-1:0]     eff_prio [N];
  logic [7:0]       age [N];
  logic [N-1:0]     promoted;
  logic [N-1:0]     sel_hot;
  logic [SEL_W-1:0] rr_pointer;
  logic             handshake;

  logic [P-1:0]     max_prio;
  logic [N-1:0]     candidate;
  logic [SEL_W-1:0] winner;
  logic [P-1:0]     winner_prio;
  logic             any_eligible;

  assign handshake    = selection_valid & selection_ready;
  assign any_eligible = |eligible;
  assign sel_hot      = {{(N-1){1'b0}}, 1'b1} << selection;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      promoted[j] = (AGING_ENABLE != 0) && (age[j] == AGE_MAX);
    end
  end

  // Eligibility travels apart from priority so a free queue at priority 0 still competes.
  always_ff @(posedge clock) begin
    if (reset) begin
      eligible <= '0;
      for (int j = 0; j < N; j++) begin
        eff_prio[j] <= '0;
      end
    end else begin
      eligible <= free;
      for (int j = 0; j < N; j++) begin
        eff_prio[j] <= promoted[j] ? {P{1'b1}} : priorities[j*P +: P];
      end
    end
  end

  generate
    if (AGING_ENABLE != 0) begin : g_aging
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int j = 0; j < N; j++) begin
            age[j] <= '0;
          end
        end else begin
          for (int j = 0; j < N; j++) begin
            if (!free[j]) begin
              age[j] <= '0;
            end else if (handshake) begin
              if (sel_hot[j]) begin
                age[j] <= '0;
              end else if (eligible[j] && age[j] != AGE_MAX) begin
                age[j] <= age[j] + 8'd1;
              end
            end
          end
        end
      end
    end else begin : g_no_aging
      always_comb begin
        for (int j = 0; j < N; j++) begin
          age[j] = '0;
        end
      end
    end
  endgenerate

  always_comb begin
    max_prio = '0;
    for (int j = 0; j < N; j++) begin
      if (eligible[j] && eff_prio[j] > max_prio) begin
        max_prio = eff_prio[j];
      end
    end
    for (int j = 0; j < N; j++) begin
      candidate[j] = eligible[j] && (eff_prio[j] == max_prio);
    end
  end

  // Scan upward from the round-robin pointer, wrapping, and take the first candidate.
  always_comb begin
    int  idx;
    logic found;
    winner      = '0;
    winner_prio = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_pointer) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && candidate[idx]) begin
        found       = 1'b1;
        winner      = idx[SEL_W-1:0];
        winner_prio = eff_prio[idx];
      end
    end
  end

  // After an accepted grant, valid drops for one cycle so `free` can reflect the dequeue.
  always_ff @(posedge clock) begin
    if (reset) begin
      selection          <= '0;
      selection_valid    <= 1'b0;
      selection_priority <= '0;
      rr_pointer         <= '0;
    end else if (selection_valid && !selection_ready) begin
      selection          <= selection;
      selection_valid    <= selection_valid;
      selection_priority <= selection_priority;
    end else if (handshake) begin
      selection_valid <= 1'b0;
      rr_pointer      <= (selection == LAST_ID) ? '0 : selection + 1'b1;
    end else if (any_eligible) begin
      selection          <= winner;
      selection_priority <= winner_prio;
      selection_valid    <= 1'b1;
    end else begin
      selection_valid <= 1'b0;
    end
  end

endmodule
